// File: rtl/reg_file_banked_pkg.sv
// Shared types for the banked register file: FSM state encoding and an
// address-width helper that keeps single-entry banks at one address bit.
package reg_file_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_file_banked_clr_counter.sv
// Sweep index for the clear pass. While start is held high, idx walks
// 0..N-1 once per cycle; done flags the last index. Low start parks idx at 0.
module clr_counter #(
  parameter int N = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [$clog2(N)-1:0] idx,
  output logic                 done
);

  localparam logic [$clog2(N)-1:0] LAST = ($clog2(N))'(N - 1);

  assign done = start && (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (!start || done) begin
      idx <= '0;
    end else begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_banked.sv
// Register file with one absolute read port, one bank-relative read port and
// one bank-relative write port, zeroed by a one-entry-per-cycle clear sweep.
module reg_file_banked
  import reg_file_pkg::*;
#(
  parameter int W       = 9,
  parameter int NREG    = 12,
  parameter int BANK    = 4,
  parameter int RT_BASE = 4,
  parameter int RD_BASE = 8,
  parameter int BYPASS  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_req,
  input  logic                    write,
  input  logic [$clog2(NREG)-1:0] rs_addr,
  input  logic [addr_w(BANK)-1:0] rt_addr,
  input  logic [addr_w(BANK)-1:0] rd_addr,
  input  logic [W-1:0]            rd_in,
  output logic [W-1:0]            rs_out,
  output logic [W-1:0]            rt_out,
  output logic                    busy,
  output logic                    wr_drop
);

  localparam int AW     = $clog2(NREG);
  localparam int RT_TOP = RT_BASE + BANK;
  localparam int RD_TOP = RD_BASE + BANK;
  localparam int SPAN_A = (RT_TOP > NREG) ? RT_TOP : NREG;
  localparam int SPAN   = (RD_TOP > SPAN_A) ? RD_TOP : SPAN_A;
  // Wide enough to hold base+offset past the array end without wrapping.
  localparam int IW     = $clog2(SPAN) + 1;

  rf_state_t         state;
  logic [AW-1:0]     idx;
  logic              done;
  logic [W-1:0]      regs [NREG];
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rs_idx;
  logic [IW-1:0]     rt_idx;
  logic              wr_ok;
  logic              wr_accept;

  clr_counter #(.N(NREG)) u_clr_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (busy),
    .idx   (idx),
    .done  (done)
  );

  assign busy      = (state == CLEAR);
  assign wr_idx    = IW'(RD_BASE) + IW'(rd_addr);
  assign rt_idx    = IW'(RT_BASE) + IW'(rt_addr);
  assign rs_idx    = IW'(rs_addr);
  assign wr_ok     = (state == READY) && write && !clr_req;
  assign wr_accept = wr_ok && (wr_idx < IW'(NREG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= write && ((state == CLEAR) || clr_req);
      if (state == CLEAR) begin
        if (done) state <= READY;
      end else if (clr_req) begin
        state <= CLEAR;
      end
    end
  end

  // Array has no reset; the sweep owns it while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      regs[idx] <= '0;
    end else if (wr_accept) begin
      regs[wr_idx[AW-1:0]] <= rd_in;
    end
  end

  always_comb begin
    rs_out = '0;
    if (!busy && (rs_idx < IW'(NREG))) begin
      if ((BYPASS != 0) && wr_accept && (wr_idx == rs_idx)) rs_out = rd_in;
      else                                                  rs_out = regs[rs_idx[AW-1:0]];
    end
  end

  always_comb begin
    rt_out = '0;
    if (!busy && (rt_idx < IW'(NREG))) begin
      if ((BYPASS != 0) && wr_accept && (wr_idx == rt_idx)) rt_out = rd_in;
      else                                                  rt_out = regs[rt_idx[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_reg_file_banked.sv
// Bench for reg_file_banked: default instance plus a BYPASS=0 instance with
// shifted banks, both checked every cycle against a behavioural model.
module tb_reg_file_banked;

  localparam int NREG = 12;
  localparam int RDB[2] = '{8, 10};
  localparam int RTB[2] = '{4, 9};
  localparam int BYP[2] = '{1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr_req = 1'b0;
  logic       write = 1'b0;
  logic [3:0] rs_addr = '0;
  logic [1:0] rt_addr = '0;
  logic [1:0] rd_addr = '0;
  logic [8:0] rd_in = '0;

  logic [8:0] rs0, rs1, rt0, rt1;
  logic       busy0, busy1, drop0, drop1;
  logic [8:0] rs_o [2];
  logic [8:0] rt_o [2];
  logic       busy_o [2];
  logic       drop_o [2];

  assign rs_o[0] = rs0;     assign rs_o[1] = rs1;
  assign rt_o[0] = rt0;     assign rt_o[1] = rt1;
  assign busy_o[0] = busy0; assign busy_o[1] = busy1;
  assign drop_o[0] = drop0; assign drop_o[1] = drop1;

  reg_file_banked dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .write(write),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rd_in(rd_in),
    .rs_out(rs0), .rt_out(rt0), .busy(busy0), .wr_drop(drop0)
  );

  reg_file_banked #(.RT_BASE(9), .RD_BASE(10), .BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .write(write),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rd_in(rd_in),
    .rs_out(rs1), .rt_out(rt1), .busy(busy1), .wr_drop(drop1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: cycles of sweep left, register contents, pending drop flag.
  logic [8:0] mregs [2][NREG];
  int         busy_left [2] = '{NREG, NREG};
  logic       mdrop [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        busy_left[k] = NREG;
        mdrop[k] = 1'b0;
      end else if (busy_left[k] > 0) begin
        mdrop[k] = write;
        busy_left[k] = busy_left[k] - 1;
        if (busy_left[k] == 0)
          for (int j = 0; j < NREG; j++) mregs[k][j] = '0;
      end else if (clr_req) begin
        mdrop[k] = write;
        busy_left[k] = NREG;
      end else begin
        mdrop[k] = 1'b0;
        if (write && (RDB[k] + int'(rd_addr) < NREG))
          mregs[k][RDB[k] + int'(rd_addr)] = rd_in;
      end
    end
  end

  function automatic logic [8:0] exp_read(input int k, input int sel);
    int widx;
    bit acc;
    widx = RDB[k] + int'(rd_addr);
    acc = (busy_left[k] == 0) && write && !clr_req && (widx < NREG);
    if (busy_left[k] > 0 || sel >= NREG) return '0;
    if (BYP[k] != 0 && acc && widx == sel) return rd_in;
    return mregs[k][sel];
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy%0d", k), {8'b0, busy_o[k]}, {8'b0, busy_left[k] > 0});
      check($sformatf("wr_drop%0d", k), {8'b0, drop_o[k]}, {8'b0, mdrop[k]});
      check($sformatf("rs_out%0d", k), rs_o[k], exp_read(k, int'(rs_addr)));
      check($sformatf("rt_out%0d", k), rt_o[k], exp_read(k, RTB[k] + int'(rt_addr)));
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input int start_n, output int n);
    n = start_n;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy0) n++;
      else if (n > 0) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy(0, n);
    check("reset_sweep_len", 9'(n), 9'd12);

    for (int i = 0; i < NREG; i++) begin
      rs_addr = 4'(i);
      rt_addr = 2'(i);
      @(negedge clk);
      check("post_reset_zero", rs0, 9'h000);
      cyc();
    end

    write = 1'b1; rd_addr = 2'd2; rd_in = 9'h1A5; rs_addr = 4'd0;
    cyc();
    write = 1'b0; rs_addr = 4'd10;
    @(negedge clk);
    check("write_rd2_dut0", rs0, 9'h1A5);
    check("write_rd2_drop", {8'b0, drop0}, 9'h000);
    check("oob_write_dut1", rs1, 9'h000);
    check("oob_write_nodrop", {8'b0, drop1}, 9'h000);
    cyc();

    write = 1'b1; rd_addr = 2'd0; rd_in = 9'h055;
    cyc();
    rd_in = 9'h07F; rs_addr = 4'd8;
    @(negedge clk);
    check("bypass_rs_dut0", rs0, 9'h07F);
    cyc();
    rd_in = 9'h0AA; rs_addr = 4'd10; rt_addr = 2'd1;
    @(negedge clk);
    check("nobypass_rs_dut1", rs1, 9'h07F);
    check("nobypass_rt_dut1", rt1, 9'h07F);
    check("rs10_dut0", rs0, 9'h1A5);
    cyc();
    write = 1'b0; rs_addr = 4'd8;
    @(negedge clk);
    check("after_write_dut0", rs0, 9'h0AA);
    check("after_write_rt_dut1", rt1, 9'h0AA);
    cyc();

    rs_addr = 4'd15; rt_addr = 2'd3; write = 1'b1; rd_addr = 2'd3; rd_in = 9'h1FF;
    @(negedge clk);
    check("rs15_dut0", rs0, 9'h000);
    check("rs15_dut1", rs1, 9'h000);
    check("rt_oob_dut1", rt1, 9'h000);
    cyc();
    write = 1'b0; rs_addr = 4'd11;
    @(negedge clk);
    check("rd3_dut0", rs0, 9'h1FF);
    check("rd13_ignored_dut1", rs1, 9'h000);
    check("rd13_nodrop_dut1", {8'b0, drop1}, 9'h000);
    cyc();

    clr_req = 1'b1; write = 1'b1; rd_addr = 2'd0; rd_in = 9'h123;
    cyc();
    @(negedge clk);
    check("clr_drop_dut0", {8'b0, drop0}, 9'h001);
    check("clr_drop_dut1", {8'b0, drop1}, 9'h001);
    check("clr_busy", {8'b0, busy0}, 9'h001);
    cyc();
    clr_req = 1'b0; write = 1'b0;
    count_busy(1, n);
    check("clr_sweep_len", 9'(n), 9'd12);
    for (int i = 0; i < NREG; i++) begin
      rs_addr = 4'(i);
      @(negedge clk);
      check("post_clr_zero", rs0, 9'h000);
      cyc();
    end

    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (5) cyc();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_sweep_reset_busy", {8'b0, busy0}, 9'h001);
    cyc();
    cyc();
    rst_n = 1'b1;
    count_busy(0, n);
    check("restart_sweep_len", 9'(n), 9'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_banked.md
REG_FILE_BANKED -- requirements
Module: reg_file_banked

Interface
REQ-001 SHALL have parameter W, default 9: register width in bits.
REQ-002 SHALL have parameter NREG, default 12: total register count.
REQ-003 SHALL have parameter BANK, default 4: registers per relative-addressed bank.
REQ-004 SHALL have parameter RT_BASE, default 4: absolute index of rt bank entry 0.
REQ-005 SHALL have parameter RD_BASE, default 8: absolute index of rd bank entry 0.
REQ-006 SHALL have parameter BYPASS, default 1: 1 = read ports forward same-cycle write data.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port clr_req, input, 1 bit: synchronous request to zero all registers.
REQ-010 SHALL have port write, input, 1 bit: write enable.
REQ-011 SHALL have port rs_addr, input, $clog2(NREG) bits: absolute read address.
REQ-012 SHALL have port rt_addr, input, $clog2(BANK) bits: read address relative to RT_BASE.
REQ-013 SHALL have port rd_addr, input, $clog2(BANK) bits: write address relative to RD_BASE.
REQ-014 SHALL have port rd_in, input, W bits: write data.
REQ-015 SHALL have port rs_out, output, W bits: combinational read data for rs.
REQ-016 SHALL have port rt_out, output, W bits: combinational read data for rt.
REQ-017 SHALL have port busy, output, 1 bit: high while the clear sweep runs.
REQ-018 SHALL have port wr_drop, output, 1 bit: registered one-cycle pulse for a rejected write.

Function
REQ-019 SHALL use a two-state FSM: CLEAR, READY.
REQ-020 In CLEAR, SHALL zero register idx (counter 0..NREG-1), one per cycle; idx NREG-1 written -> READY next cycle; sweep takes exactly NREG cycles.
REQ-021 In READY, clr_req=1 SHALL enter CLEAR with idx=0 next cycle; clr_req in CLEAR SHALL be ignored (no restart).
REQ-022 busy SHALL equal (state==CLEAR).
REQ-023 In READY with write=1, SHALL write rd_in to regs[RD_BASE+rd_addr] at the clock edge.
REQ-024 Write with busy=1, or with clr_req=1 in READY, SHALL be discarded and set wr_drop=1 for the next cycle; otherwise wr_drop=0.
REQ-025 rs_out SHALL be regs[rs_addr]; rs_addr >= NREG SHALL read 0.
REQ-026 rt_out SHALL be regs[RT_BASE+rt_addr]; index >= NREG SHALL read 0.
REQ-027 Write index >= NREG SHALL be discarded without wr_drop.
REQ-028 If BYPASS=1 and an accepted write targets the index a read port selects, that port SHALL output rd_in in the same cycle; BYPASS=0 SHALL output the old value.
REQ-029 While busy=1, rs_out and rt_out SHALL read 0.
REQ-030 Register contents SHALL be updated only by accepted writes and the clear sweep.

Reset
REQ-031 rst_n low SHALL asynchronously set state=CLEAR, idx=0, wr_drop=0; register array is not reset directly.
REQ-032 After rst_n rises, the sweep SHALL run NREG cycles; busy=1 throughout, READY on cycle NREG.
REQ-033 Reset asserted mid-sweep or mid-write SHALL abort it and restart the sweep from idx 0.

Structure
REQ-034 State enum (CLEAR, READY) SHALL live in shared package reg_file_pkg.
REQ-035 Sweep counter with terminal flag SHALL be a sub-module clr_counter (parameter N, ports clk, rst_n, start, idx, done).
REQ-036 The design SHALL elaborate for any NREG>=2, BANK>=1, W>=1; bases plus BANK may exceed NREG (handled by REQ-026/027).

Verification
REQ-037 Reset release, defaults -> busy=1 for 12 cycles, then busy=0; rs_out=0 for rs_addr 0..11.
REQ-038 READY: write=1, rd_addr=2, rd_in=9'h1A5 -> next cycle rs_addr=10 reads 9'h1A5; wr_drop=0.
REQ-039 BYPASS=1: write rd_addr=0, rd_in=9'h07F with rt_addr=... rs_addr=8 -> rs_out=9'h07F same cycle; BYPASS=0 -> old value.
REQ-040 clr_req=1 together with write=1 -> write dropped, wr_drop=1 next cycle, busy=1 for 12 cycles, all registers read 0 after.
REQ-041 rst_n pulsed low at sweep cycle 5 -> busy stays high; READY 12 cycles after rst_n rises.
REQ-042 rs_addr=15 (NREG=12) -> rs_out=0; RD_BASE=10, rd_addr=3 write -> no change, wr_drop=0.
